// File: rtl/knn_drv_pkg.sv
// Shared definitions for the KNN bus driver.
// Holds the KNN peripheral register map (word addresses), the slot and
// result counts of the peripheral, and the driver FSM state encoding.
package knn_drv_pkg;

    // Peripheral geometry: 8 data-point slots per batch, 6 nearest neighbours.
    localparam int KNN_SLOTS = 8;
    localparam int KNN_K     = 6;
    localparam int KNN_RES   = 2 * KNN_K;  // KN1..KN6 then IN1..IN6

    // Register map (word addresses)
    localparam logic [4:0] REG_RESET     = 5'd0;
    localparam logic [4:0] REG_START     = 5'd1;
    localparam logic [4:0] REG_VALID_IN  = 5'd2;
    localparam logic [4:0] REG_TEST_PT   = 5'd4;
    localparam logic [4:0] REG_DATA_PT1  = 5'd5;
    localparam logic [4:0] REG_VALID_OUT = 5'd13;
    localparam logic [4:0] REG_KN1       = 5'd14;
    localparam logic [4:0] REG_IN1       = 5'd20;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RST_HI,
        S_RST_LO,
        S_WR_TEST,
        S_WR_START,
        S_WR_PT,
        S_VIN_HI,
        S_VIN_LO,
        S_POLL,
        S_RD_RES,
        S_EMIT,
        S_FIN
    } state_t;

endpackage

// File: rtl/knn_bus_driver_bus_req.sv
// Single-transaction native-bus initiator.
// A request presented while the bus is idle is registered onto m_*; the
// request is then held unchanged until the slave answers with m_ready.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req, we, addr, wdata  request from the controlling FSM
//   ack                 high in the cycle the slave completes (m_valid & m_ready)
//   rdata               slave read data, meaningful while ack is high
//   m_valid, m_addr, m_wdata, m_wstrb   native-bus request outputs
//   m_rdata, m_ready    native-bus response inputs
module knn_bus_req
    import knn_drv_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready
);

    // While a request is outstanding, req is ignored; after completion
    // m_valid drops for at least one cycle before the next launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wstrb <= 4'h0;
        end else if (m_valid) begin
            if (m_ready) begin
                m_valid <= 1'b0;
            end
        end else if (req) begin
            m_valid <= 1'b1;
            m_addr  <= addr;
            m_wdata <= wdata;
            m_wstrb <= we ? 4'hF : 4'h0;
        end
    end

    assign ack   = m_valid & m_ready;
    assign rdata = m_rdata;

endmodule

// File: rtl/knn_bus_driver.sv
// KNN bus driver: hardware replacement for the CPU register sequence that
// runs a KNN job. Resets the peripheral, writes the test point, streams
// the data points in batches of 8 (padding the last batch), polls
// VALID_OUT and returns the 12 result words on a valid/ready stream.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, num_pts, test_pt  job request (sampled only when idle)
//   pt_valid, pt_data, pt_ready   data-point input stream
//   m_valid, m_addr, m_wdata, m_wstrb, m_rdata, m_ready   native bus
//   res_valid, res_idx, res_data, res_ready   result stream
//   busy, done, err          job status; err = poll timeout, valid with done
module knn_bus_driver
    import knn_drv_pkg::*;
#(
    parameter int              ADDR_W    = 5,
    parameter int              DATA_W    = 32,
    parameter int              NPTS_W    = 16,
    parameter logic [DATA_W-1:0] PAD_VALUE = 32'hFFFF_FFFF,
    parameter int              POLL_MAX  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NPTS_W-1:0] num_pts,
    input  logic [DATA_W-1:0] test_pt,
    input  logic              pt_valid,
    input  logic [DATA_W-1:0] pt_data,
    output logic              pt_ready,
    output logic              m_valid,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [3:0]        m_wstrb,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ready,
    output logic              res_valid,
    output logic [3:0]        res_idx,
    output logic [DATA_W-1:0] res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int POLL_W = $clog2(POLL_MAX + 1);

    state_t              state, state_next;
    logic [NPTS_W-1:0]   pts_left;
    logic [2:0]          slot;
    logic [3:0]          res_k;
    logic [POLL_W-1:0]   poll_cnt;
    logic [DATA_W-1:0]   tp_q;

    logic                bus_req;
    logic                bus_we;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic                bus_ack;
    logic [DATA_W-1:0]   bus_rdata;

    logic                pts_remain;
    logic                poll_last;

    assign pts_remain = (pts_left != '0);
    assign poll_last  = (poll_cnt == POLL_W'(POLL_MAX - 1));

    knn_bus_req #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_bus (
        .clk     (clk),
        .rst     (rst),
        .req     (bus_req),
        .we      (bus_we),
        .addr    (bus_addr),
        .wdata   (bus_wdata),
        .ack     (bus_ack),
        .rdata   (bus_rdata),
        .m_valid (m_valid),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_wstrb (m_wstrb),
        .m_rdata (m_rdata),
        .m_ready (m_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_wdata  = '0;
        pt_ready   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (num_pts == '0) ? S_FIN : S_RST_HI;
                end
            end
            S_RST_HI: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = ADDR_W'(REG_RESET);
                bus_wdata = DATA_W'(1);
                if (bus_ack) state_next = S_RST_LO;
            end
            S_RST_LO: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = ADDR_W'(REG_RESET);
                if (bus_ack) state_next = S_WR_TEST;
            end
            S_WR_TEST: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = ADDR_W'(REG_TEST_PT);
                bus_wdata = tp_q;
                if (bus_ack) state_next = S_WR_START;
            end
            S_WR_START: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = ADDR_W'(REG_START);
                bus_wdata = DATA_W'(1);
                if (bus_ack) state_next = S_WR_PT;
            end
            S_WR_PT: begin
                bus_we   = 1'b1;
                bus_addr = ADDR_W'(REG_DATA_PT1) + ADDR_W'(slot);
                if (pts_remain) begin
                    // A point is only taken when it can launch immediately,
                    // so the stream never runs ahead of the bus.
                    pt_ready  = !m_valid;
                    bus_req   = pt_valid && !m_valid;
                    bus_wdata = pt_data;
                end else begin
                    bus_req   = 1'b1;
                    bus_wdata = PAD_VALUE;
                end
                if (bus_ack) begin
                    state_next = (slot == 3'(KNN_SLOTS - 1)) ? S_VIN_HI : S_WR_PT;
                end
            end
            S_VIN_HI: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = ADDR_W'(REG_VALID_IN);
                bus_wdata = DATA_W'(1);
                if (bus_ack) state_next = S_VIN_LO;
            end
            S_VIN_LO: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = ADDR_W'(REG_VALID_IN);
                if (bus_ack) state_next = pts_remain ? S_WR_PT : S_POLL;
            end
            S_POLL: begin
                bus_req  = 1'b1;
                bus_addr = ADDR_W'(REG_VALID_OUT);
                if (bus_ack) begin
                    if (bus_rdata[0]) begin
                        state_next = S_RD_RES;
                    end else if (poll_last) begin
                        state_next = S_FIN;
                    end
                end
            end
            S_RD_RES: begin
                bus_req  = 1'b1;
                bus_addr = ADDR_W'(REG_KN1) + ADDR_W'(res_k);
                if (bus_ack) state_next = S_EMIT;
            end
            S_EMIT: begin
                if (res_ready) begin
                    state_next = (res_k == 4'(KNN_RES - 1)) ? S_FIN : S_RD_RES;
                end
            end
            S_FIN: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Job control and result registers. slot is 3 bits and wraps to 0 after
    // the eighth write, which is exactly the start of the next batch.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            res_valid <= 1'b0;
            res_idx   <= 4'd0;
            res_data  <= '0;
            pts_left  <= '0;
            slot      <= 3'd0;
            res_k     <= 4'd0;
            poll_cnt  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        err      <= 1'b0;
                        pts_left <= num_pts;
                        slot     <= 3'd0;
                        res_k    <= 4'd0;
                        poll_cnt <= '0;
                    end
                end
                S_WR_PT: begin
                    if (bus_ack) begin
                        slot <= slot + 3'd1;
                        if (pts_remain) pts_left <= pts_left - NPTS_W'(1);
                    end
                end
                S_POLL: begin
                    if (bus_ack && !bus_rdata[0]) begin
                        poll_cnt <= poll_cnt + POLL_W'(1);
                        if (poll_last) err <= 1'b1;
                    end
                end
                S_RD_RES: begin
                    if (bus_ack) begin
                        res_data  <= bus_rdata;
                        res_idx   <= res_k;
                        res_valid <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_k     <= res_k + 4'd1;
                    end
                end
                S_FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    // Test point is plain data: captured on an accepted start, never reset.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && start) begin
            tp_q <= test_pt;
        end
    end

endmodule

// File: tb/tb_knn_bus_driver.sv
module tb_knn_bus_driver;

    localparam int POLL_MAX = 4;
    localparam int NV       = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [15:0] num_pts;
    logic [31:0] test_pt;
    logic        pt_valid;
    logic [31:0] pt_data;
    logic        pt_ready;
    logic        m_valid;
    logic [4:0]  m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        res_valid;
    logic [3:0]  res_idx;
    logic [31:0] res_data;
    logic        res_ready;
    logic        busy;
    logic        done;
    logic        err;

    knn_bus_driver #(
        .ADDR_W    (5),
        .DATA_W    (32),
        .NPTS_W    (16),
        .PAD_VALUE (32'hFFFF_FFFF),
        .POLL_MAX  (POLL_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_pts   (num_pts),
        .test_pt   (test_pt),
        .pt_valid  (pt_valid),
        .pt_data   (pt_data),
        .pt_ready  (pt_ready),
        .m_valid   (m_valid),
        .m_addr    (m_addr),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_rdata   (m_rdata),
        .m_ready   (m_ready),
        .res_valid (res_valid),
        .res_idx   (res_idx),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [7:0]  vid;
        int          n;
        logic [31:0] tp;
        int          lat;
        int          pz;
        int          stall;
        bit          gaps;
        bit          exp_err;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } txn_t;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } res_t;

    vec_t        vecs[NV];
    txn_t        exp_txn[$];
    res_t        exp_res[$];
    logic [31:0] pts[$];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          wcnt;
    txn_t        held;
    logic [3:0]  held_strb;
    bit          pt_hs;
    int          pt_idx;
    int          hs_count;
    int          poll_reads;
    int          cur_lat;
    int          cur_pz;
    int          stall_left;
    bit          cur_gaps;
    logic [7:0]  cur_vid;
    bit          done_seen;
    logic        err_seen;
    bit          prev_stall;
    logic [3:0]  prev_idx;
    logic [31:0] prev_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] kn_val(input logic [7:0] vid, input int a);
        return 32'hA500_0000 | (32'(vid) << 8) | 32'(a);
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 time unit later.
    task automatic step();
        txn_t e;
        res_t r;
        @(negedge clk);
        start   = 1'b0;
        m_ready = 1'b0;
        if (m_valid && !rst) begin
            if (wcnt == 0) begin
                held.we   = (m_wstrb == 4'hF);
                held.addr = m_addr;
                held.data = m_wdata;
                held_strb = m_wstrb;
            end else begin
                chk("hold_addr",  32'(m_addr),  32'(held.addr));
                chk("hold_wdata", m_wdata,      held.data);
                chk("hold_wstrb", 32'(m_wstrb), 32'(held_strb));
            end
            if (wcnt >= cur_lat) begin
                m_ready = 1'b1;
                m_rdata = 32'hDEAD_BEEF;
                if (m_wstrb == 4'h0) begin
                    if (m_addr == 5'd13) begin
                        m_rdata = (poll_reads >= cur_pz) ? 32'h0000_0001 : 32'hFFFF_FFFE;
                        poll_reads++;
                    end else if (m_addr >= 5'd14 && m_addr <= 5'd25) begin
                        m_rdata = kn_val(cur_vid, int'(m_addr));
                    end
                end
                if (exp_txn.size() == 0) begin
                    chk("txn_unexpected_addr", 32'(m_addr), 32'hFFFF_FFFF);
                end else begin
                    e = exp_txn.pop_front();
                    chk("txn_wstrb", 32'(m_wstrb), e.we ? 32'hF : 32'h0);
                    chk("txn_addr",  32'(m_addr),  32'(e.addr));
                    if (e.we) chk("txn_wdata", m_wdata, e.data);
                end
                wcnt = 0;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end

        if (pt_hs) pt_idx++;
        pt_valid = 1'b0;
        pt_data  = 32'h0;
        if (pt_idx < pts.size() && !(cur_gaps && $urandom_range(0, 2) == 0)) begin
            pt_valid = 1'b1;
            pt_data  = pts[pt_idx];
        end

        res_ready = 1'b1;
        if (res_valid && res_idx == 4'd0 && stall_left > 0) begin
            res_ready = 1'b0;
            stall_left--;
        end

        #1;
        pt_hs = pt_valid && pt_ready;
        if (pt_hs) hs_count++;
        if (prev_stall) begin
            chk("stall_res_valid", 32'(res_valid), 32'h1);
            chk("stall_res_idx",   32'(res_idx),   32'(prev_idx));
            chk("stall_res_data",  res_data,       prev_data);
        end
        if (res_valid) chk("no_bus_while_res_valid", 32'(m_valid), 32'h0);
        prev_stall = res_valid && !res_ready;
        prev_idx   = res_idx;
        prev_data  = res_data;
        if (res_valid && res_ready) begin
            if (exp_res.size() == 0) begin
                chk("res_unexpected_idx", 32'(res_idx), 32'hFFFF_FFFF);
            end else begin
                r = exp_res.pop_front();
                chk("res_idx",  32'(res_idx), 32'(r.idx));
                chk("res_data", res_data,     r.data);
            end
        end
        if (done) begin
            done_seen = 1'b1;
            err_seen  = err;
        end
    endtask

    task automatic push_txn(input logic we, input int a, input logic [31:0] d);
        txn_t t;
        t.we   = we;
        t.addr = 5'(a);
        t.data = d;
        exp_txn.push_back(t);
    endtask

    task automatic begin_job(input vec_t v);
        int   nb;
        int   npoll;
        res_t r;
        exp_txn.delete();
        exp_res.delete();
        pts.delete();
        pt_idx     = 0;
        pt_hs      = 1'b0;
        hs_count   = 0;
        poll_reads = 0;
        wcnt       = 0;
        prev_stall = 1'b0;
        cur_lat    = v.lat;
        cur_pz     = v.pz;
        stall_left = v.stall;
        cur_gaps   = v.gaps;
        cur_vid    = v.vid;
        done_seen  = 1'b0;
        err_seen   = 1'b0;
        for (int i = 0; i < v.n; i++) pts.push_back((32'(v.vid) << 16) | 32'(i + 1));
        if (v.n > 0) begin
            push_txn(1'b1, 0, 32'd1);
            push_txn(1'b1, 0, 32'd0);
            push_txn(1'b1, 4, v.tp);
            push_txn(1'b1, 1, 32'd1);
            nb = (v.n + 7) / 8;
            for (int b = 0; b < nb; b++) begin
                for (int s = 0; s < 8; s++) begin
                    if (b * 8 + s < v.n) push_txn(1'b1, 5 + s, pts[b * 8 + s]);
                    else                 push_txn(1'b1, 5 + s, 32'hFFFF_FFFF);
                end
                push_txn(1'b1, 2, 32'd1);
                push_txn(1'b1, 2, 32'd0);
            end
            npoll = (v.pz >= POLL_MAX) ? POLL_MAX : v.pz + 1;
            for (int p = 0; p < npoll; p++) push_txn(1'b0, 13, 32'd0);
            if (!v.exp_err) begin
                for (int k = 0; k < 12; k++) begin
                    push_txn(1'b0, 14 + k, 32'd0);
                    r.idx  = 4'(k);
                    r.data = kn_val(v.vid, 14 + k);
                    exp_res.push_back(r);
                end
            end
        end
        num_pts = 16'(v.n);
        test_pt = v.tp;
        start   = 1'b1;
        step();
        chk("busy_after_start", 32'(busy), 32'h1);
        chk("err_cleared_on_start", 32'(err), 32'h0);
    endtask

    task automatic finish_job(input vec_t v);
        for (int cyc = 0; cyc < 4000 && !done_seen; cyc++) step();
        chk("done_seen",     32'(done_seen), 32'h1);
        chk("err_at_done",   32'(err_seen),  32'(v.exp_err));
        chk("pt_handshakes", 32'(hs_count),  32'(v.n));
        chk("txns_left",     32'(exp_txn.size()), 32'h0);
        chk("results_left",  32'(exp_res.size()), 32'h0);
        step();
        chk("done_one_cycle",  32'(done), 32'h0);
        chk("busy_after_done", 32'(busy), 32'h0);
        chk("err_held",        32'(err),  32'(v.exp_err));
    endtask

    task automatic check_reset_vals();
        chk("rst_m_valid",   32'(m_valid),   32'h0);
        chk("rst_m_addr",    32'(m_addr),    32'h0);
        chk("rst_m_wdata",   m_wdata,        32'h0);
        chk("rst_m_wstrb",   32'(m_wstrb),   32'h0);
        chk("rst_pt_ready",  32'(pt_ready),  32'h0);
        chk("rst_res_valid", 32'(res_valid), 32'h0);
        chk("rst_res_idx",   32'(res_idx),   32'h0);
        chk("rst_res_data",  res_data,       32'h0);
        chk("rst_busy",      32'(busy),      32'h0);
        chk("rst_done",      32'(done),      32'h0);
        chk("rst_err",       32'(err),       32'h0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_pts = 16'd0; test_pt = 32'd0;
        pt_valid = 1'b0; pt_data = 32'd0; m_rdata = 32'd0; m_ready = 1'b0; res_ready = 1'b1;
        wcnt = 0; pt_hs = 1'b0; pt_idx = 0; hs_count = 0; poll_reads = 0;
        cur_lat = 0; cur_pz = 0; stall_left = 0; cur_gaps = 1'b0; cur_vid = 8'd0;
        done_seen = 1'b0; err_seen = 1'b0; prev_stall = 1'b0; prev_idx = 4'd0; prev_data = 32'd0;
        held.we = 1'b0; held.addr = 5'd0; held.data = 32'd0; held_strb = 4'h0;

        //          vid   n   test_pt        lat pz  stall gaps err
        vecs[0] = '{8'd0, 8,  32'h0000_0010, 0,  0,  0,    0,   0};  // nominal
        vecs[1] = '{8'd1, 11, 32'h0000_1234, 0,  0,  0,    0,   0};  // partial batch
        vecs[2] = '{8'd2, 8,  32'h0000_0010, 3,  0,  0,    0,   0};  // slow slave
        vecs[3] = '{8'd3, 5,  32'h0000_0007, 0,  99, 0,    0,   1};  // poll timeout
        vecs[4] = '{8'd4, 3,  32'h8000_0001, 1,  3,  0,    0,   0};  // ready on last allowed poll
        vecs[5] = '{8'd5, 0,  32'h0000_0055, 0,  0,  0,    0,   0};  // empty job
        vecs[6] = '{8'd6, 16, 32'hCAFE_F00D, 2,  1,  0,    1,   0};  // two full batches, gappy stream
        vecs[7] = '{8'd7, 8,  32'h0000_0010, 0,  0,  10,   1,   0};  // result backpressure

        repeat (3) step();
        check_reset_vals();
        rst = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            begin_job(vecs[i]);
            finish_job(vecs[i]);
        end

        // Reset while the slot-3 write (addr 8) is on the bus.
        begin_job(vecs[0]);
        for (int cyc = 0; cyc < 500 && !(m_valid && m_addr == 5'd8); cyc++) step();
        chk("reached_slot3", 32'(m_addr), 32'd8);
        rst      = 1'b1;
        m_ready  = 1'b0;
        pt_valid = 1'b0;
        step();
        check_reset_vals();
        rst = 1'b0;
        step();
        begin_job(vecs[0]);
        finish_job(vecs[0]);

        // start and rst together: reset takes priority.
        num_pts = 16'd8;
        test_pt = 32'h10;
        start   = 1'b1;
        rst     = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_beats_start_busy", 32'(busy), 32'h0);
        step();
        step();
        chk("rst_beats_start_no_bus", 32'(m_valid), 32'h0);
        chk("rst_beats_start_idle",   32'(busy),    32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/knn_bus_driver.md
Name: knn_bus_driver

Overview:
- Native-bus initiator that drives the KNN peripheral's CPU slave interface in hardware, replacing software register pokes.
- Pulls a test point and N data points from an input stream and writes them to the KNN register file in batches of 8. Polls for completion, reads back the 6 distances and 6 indices, and emits them on a result stream.
- Sits between a data source (memory streamer or test harness) and the KNN peripheral, on the same clock.

Parameters:
- ADDR_W, 5: native-bus word address width.
- DATA_W, 32: bus data width.
- NPTS_W, 16: width of the num_pts count.
- PAD_VALUE, 32'hFFFF_FFFF: value written to unused data-point slots in a partial batch.
- POLL_MAX, 1024: maximum VALID_OUT reads before timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle job start; ignored while busy
- num_pts  in  NPTS_W  number of data points; sampled on start
- test_pt  in  DATA_W  test point; sampled on start
- pt_valid  in  1  data-point stream valid
- pt_data  in  DATA_W  data point
- pt_ready  out  1  data-point accepted when pt_valid & pt_ready
- m_valid  out  1  bus request
- m_addr  out  ADDR_W  word address
- m_wdata  out  DATA_W  write data
- m_wstrb  out  4  4'hF for write, 4'h0 for read
- m_rdata  in  DATA_W  read data, valid in the cycle m_ready=1
- m_ready  in  1  slave completion
- res_valid  out  1  result word valid
- res_idx  out  4  0..5 = KN1..KN6, 6..11 = IN1..IN6
- res_data  out  DATA_W  result word (IN values zero-extended by slave)
- res_ready  in  1  result accepted
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err  out  1  poll timeout flag; valid with done, cleared on next accepted start

Behaviour:
- Reset values: m_valid, m_addr, m_wdata, m_wstrb, pt_ready, res_valid, res_idx, res_data, busy, done and err are all 0. State returns to IDLE. A reset mid-transaction drops m_valid at the next edge and abandons the transaction.
- Bus rules:
  - One outstanding transaction.
  - m_valid stays high, with m_addr, m_wdata and m_wstrb stable, until the cycle m_ready=1.
  - The next request is no earlier than the following cycle.
  - Read data is captured in the m_ready cycle.
- Register map (word addresses): RESET 0, START 1, VALID_IN 2, TEST_PT 4, DATA_PT1..8 5..12, VALID_OUT 13, KN1..6 14..19, IN1..6 20..25.
- FSM:
  - IDLE: on start, latch num_pts and test_pt, clear err, set busy. If num_pts==0, pulse done the next cycle with no bus traffic.
  - RST_HI: write 1 to addr 0. RST_LO: write 0 to addr 0.
  - WR_TEST: write test_pt to addr 4. WR_START: write 1 to addr 1.
  - WR_PT, slot s=0..7:
    - If points remain, assert pt_ready only when no request is pending. On pt handshake, issue a write of pt_data to addr 5+s.
    - If no pt_valid, m_valid stays 0 (wait).
    - If the point count is exhausted, write PAD_VALUE without consuming the stream.
  - VIN_HI: write 1 to addr 2. VIN_LO: write 0 to addr 2. Then, if points remain, return to WR_PT with s=0; otherwise go to POLL.
  - POLL:
    - Read addr 13. If bit0=1, go to RD_RES.
    - Otherwise increment the poll count. When the count reaches POLL_MAX, set err and go to FIN.
  - RD_RES, k=0..11: read addr 14+k, capture the word into res_data, set res_idx=k, go to EMIT.
  - EMIT: hold res_valid until res_ready, then go to k+1 or FIN. No bus read is issued while res_valid=1.
  - FIN: pulse done for 1 cycle, clear busy, go to IDLE.
- Point counter width is NPTS_W. Batch count is ceil(num_pts/8); no wrap. start, num_pts and test_pt are ignored while busy.
- A simultaneous start and rst: rst wins.

Decomposition:
- Shared package knn_drv_pkg holds:
  - register address constants;
  - FSM state encoding;
  - KNN_SLOTS=8 and KNN_K=6.
- One sub-module, knn_bus_req, issues a single native-bus transaction. It takes req/we/addr/wdata, drives the m_* port signals, and returns ack/rdata. It enforces the hold-until-ready rule. The FSM lives in knn_bus_driver.

Test Plan:
- Nominal run: num_pts=8, test_pt=32'h10, points 1..8, m_ready=1 every request, VALID_OUT returns 1 on the first poll.
  - Required writes, in order: 0←1, 0←0, 4←0x10, 1←1, 5..12←1..8, 2←1, 2←0.
  - Then: read 13, reads 14..25.
  - 12 results with res_idx 0..11 carrying the slave data; done=1 for one cycle; err=0.
- Partial batch: num_pts=11. Second batch writes slots 5..7 with points 9..11 and slots 8..12 with 0xFFFFFFFF; exactly 11 pt handshakes total.
- Slow slave: m_ready asserted 3 cycles after each m_valid. m_valid, m_addr and m_wdata stay stable across the wait; no request overlap; same sequence as the nominal run.
- Timeout: slave returns VALID_OUT=0 always, POLL_MAX=4. Exactly 4 reads of addr 13, then done with err=1, no reads of 14..25.
- Backpressure: res_ready=0 for 10 cycles on result 0. res_valid, res_idx=0 and res_data stay stable; no m_valid during the stall; results 1..11 follow normally.
- Reset mid-run: rst during WR_PT slot 3. All outputs read their reset values after the edge; a new start then produces the full nominal sequence from RST_HI.
